product_accumulator: RTL and testbench



---
 rtl/product_accumulator_if.sv | 36 +++
 rtl/product_accumulator.sv | 110 +++++++++++
 tb/tb_product_accumulator.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Handshake and data bundle between a product source and product_accumulator.
// The master drives start/clr/p_in/p_valid; the slave returns the sum and status.
interface product_accumulator_if #(
    parameter int ACC_W = 24
);
    logic             start;
    logic             clr;
    logic [15:0]      p_in;
    logic             p_valid;
    logic [ACC_W-1:0] acc_out;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start,
        output clr,
        output p_in,
        output p_valid,
        input  acc_out,
        input  busy,
        input  done,
        input  ovf
    );

    modport slave (
        input  start,
        input  clr,
        input  p_in,
        input  p_valid,
        output acc_out,
        output busy,
        output done,
        output ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums a run of LEN unsigned 16-bit products into an ACC_W-bit accumulator.
// Optional PRODUCT_ACC_SATURATE_EN clamps the sum on overflow instead of wrapping.
module product_accumulator #(
    parameter int LEN   = 8,
    parameter int ACC_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    product_accumulator_if.slave bus
);
    localparam int               CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [ACC_W-1:0] w_acc_add;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic [ACC_W:0]   w_sum;

    // One extra bit so the carry out of the accumulator is observable.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W-15){1'b0}}, bus.p_in};

`ifdef PRODUCT_ACC_SATURATE_EN
    // Once the run has overflowed the sum stays pinned at all-ones.
    assign w_acc_add = (w_sum[ACC_W] | r_ovf) ? {ACC_W{1'b1}}
                                              : w_sum[ACC_W-1:0];
`else
    // Plain modulo 2^ACC_W accumulation.
    assign w_acc_add = w_sum[ACC_W-1:0];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update; clr overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        if (bus.clr) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = S_ACCUM;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (bus.p_valid) begin
                        w_acc_nxt = w_acc_add;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        w_ovf_nxt = r_ovf | w_sum[ACC_W];
                        if (r_cnt == LAST) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Accumulator, product count and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign bus.acc_out = r_acc;
    assign bus.ovf     = r_ovf;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator in three configurations.
// Overflow expectations follow PRODUCT_ACC_SATURATE_EN when it is defined.
module tb_product_accumulator;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    product_accumulator_if #(.ACC_W(24)) if_a ();
    product_accumulator_if #(.ACC_W(24)) if_b ();
    product_accumulator_if #(.ACC_W(18)) if_c ();

    product_accumulator #(.LEN(4), .ACC_W(24)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    product_accumulator #(.LEN(8), .ACC_W(24)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    product_accumulator #(.LEN(5), .ACC_W(18)) u_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_c)
    );

`ifdef PRODUCT_ACC_SATURATE_EN
    localparam logic [17:0] OVF_EXP = 18'h3FFFF;
`else
    localparam logic [17:0] OVF_EXP = 18'h0F605;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (if_a.acc_out !== 24'h0) begin
            errors++;
            $display("FAIL reset_acc: got %0h exp 0", if_a.acc_out);
        end
        checks++;
        if ({if_a.busy, if_a.done, if_a.ovf} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 000",
                     {if_a.busy, if_a.done, if_a.ovf});
        end
        checks++;
        if ({if_b.busy, if_c.busy, if_c.ovf} !== 3'b000) begin
            errors++;
            $display("FAIL reset_bc: got %b exp 000",
                     {if_b.busy, if_c.busy, if_c.ovf});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int sum;
        sum = 0;
        if_a.start   = 1'b1;
        if_a.p_valid = 1'b1;
        if_a.p_in    = 16'h0055;
        step();
        checks++;
        if (if_a.busy !== 1'b1 || if_a.acc_out !== 24'h0) begin
            errors++;
            $display("FAIL basic_start: got busy=%b acc=%0h exp busy=1 acc=0",
                     if_a.busy, if_a.acc_out);
        end
        if_a.start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if_a.p_valid = 1'b1;
            if_a.p_in    = 16'(i);
            sum += i;
            step();
            checks++;
            if (if_a.acc_out !== 24'(sum) || if_a.done !== (i == 4)) begin
                errors++;
                $display("FAIL basic_step%0d: got acc=%0d done=%b exp acc=%0d done=%b",
                         i, if_a.acc_out, if_a.done, sum, (i == 4));
            end
        end
        if_a.p_valid = 1'b0;
        checks++;
        if (if_a.ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_ovf: got %b exp 0", if_a.ovf);
        end
        step();
        checks++;
        if (if_a.done !== 1'b0 || if_a.busy !== 1'b0 || if_a.acc_out !== 24'd10) begin
            errors++;
            $display("FAIL basic_end: got done=%b busy=%b acc=%0d exp 0 0 10",
                     if_a.done, if_a.busy, if_a.acc_out);
        end
        step();
        checks++;
        if (if_a.acc_out !== 24'd10) begin
            errors++;
            $display("FAIL basic_hold: got %0d exp 10", if_a.acc_out);
        end
    endtask

    task automatic test_bubbles();
        int sum;
        sum = 0;
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if_a.p_valid = 1'b0;
            if_a.p_in    = 16'hFFFF;
            step();
            checks++;
            if (if_a.acc_out !== 24'(sum) || if_a.done !== 1'b0) begin
                errors++;
                $display("FAIL bubble_idle%0d: got acc=%0h done=%b exp acc=%0h done=0",
                         i, if_a.acc_out, if_a.done, sum);
            end
            if_a.p_valid = 1'b1;
            if_a.p_in    = 16'(i);
            sum += i;
            step();
        end
        if_a.p_valid = 1'b0;
        checks++;
        if (if_a.acc_out !== 24'd10 || if_a.done !== 1'b1) begin
            errors++;
            $display("FAIL bubble_end: got acc=%0d done=%b exp acc=10 done=1",
                     if_a.acc_out, if_a.done);
        end
        step();
        checks++;
        if (if_a.done !== 1'b0 || if_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL bubble_idle: got done=%b busy=%b exp 0 0",
                     if_a.done, if_a.busy);
        end
    endtask

    task automatic test_max();
        if_b.start = 1'b1;
        step();
        if_b.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if_b.p_valid = 1'b1;
            if_b.p_in    = 16'hFE01;
            step();
        end
        if_b.p_valid = 1'b0;
        checks++;
        if (if_b.acc_out !== 24'h07F008 || if_b.ovf !== 1'b0 || if_b.done !== 1'b1) begin
            errors++;
            $display("FAIL max_ops: got acc=%0h ovf=%b done=%b exp 7f008 0 1",
                     if_b.acc_out, if_b.ovf, if_b.done);
        end
        step();
        checks++;
        if (if_b.busy !== 1'b0) begin
            errors++;
            $display("FAIL max_idle: got busy=%b exp 0", if_b.busy);
        end
    endtask

    task automatic test_overflow();
        if_c.start = 1'b1;
        step();
        if_c.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_c.p_valid = 1'b1;
            if_c.p_in    = 16'hFE01;
            step();
        end
        checks++;
        if (if_c.acc_out !== 18'h3F804 || if_c.ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pre: got acc=%0h ovf=%b exp 3f804 0",
                     if_c.acc_out, if_c.ovf);
        end
        step();
        if_c.p_valid = 1'b0;
        checks++;
        if (if_c.acc_out !== OVF_EXP || if_c.ovf !== 1'b1 || if_c.done !== 1'b1) begin
            errors++;
            $display("FAIL ovf_last: got acc=%0h ovf=%b done=%b exp %0h 1 1",
                     if_c.acc_out, if_c.ovf, if_c.done, OVF_EXP);
        end
        step();
        checks++;
        if (if_c.acc_out !== OVF_EXP || if_c.ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: got acc=%0h ovf=%b exp %0h 1",
                     if_c.acc_out, if_c.ovf, OVF_EXP);
        end
        if_c.start = 1'b1;
        step();
        if_c.start = 1'b0;
        checks++;
        if (if_c.ovf !== 1'b0 || if_c.acc_out !== 18'h0 || if_c.busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_restart: got ovf=%b acc=%0h busy=%b exp 0 0 1",
                     if_c.ovf, if_c.acc_out, if_c.busy);
        end
        if_c.clr = 1'b1;
        step();
        if_c.clr = 1'b0;
    endtask

    task automatic test_abort();
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            if_a.p_valid = 1'b1;
            if_a.p_in    = 16'(i);
            step();
        end
        if_a.clr     = 1'b1;
        if_a.start   = 1'b1;
        if_a.p_valid = 1'b1;
        if_a.p_in    = 16'd9;
        step();
        checks++;
        if ({if_a.busy, if_a.done, if_a.ovf} !== 3'b000 || if_a.acc_out !== 24'h0) begin
            errors++;
            $display("FAIL abort_clr: got busy=%b done=%b ovf=%b acc=%0h exp 0 0 0 0",
                     if_a.busy, if_a.done, if_a.ovf, if_a.acc_out);
        end
        if_a.clr     = 1'b0;
        if_a.start   = 1'b0;
        if_a.p_valid = 1'b0;
        step();
        checks++;
        if (if_a.done !== 1'b0 || if_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone: got done=%b busy=%b exp 0 0",
                     if_a.done, if_a.busy);
        end
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_a.p_valid = 1'b1;
            if_a.p_in    = 16'd5;
            step();
        end
        if_a.p_valid = 1'b0;
        checks++;
        if (if_a.acc_out !== 24'd20 || if_a.done !== 1'b1) begin
            errors++;
            $display("FAIL abort_rerun: got acc=%0d done=%b exp 20 1",
                     if_a.acc_out, if_a.done);
        end
        step();
    endtask

    task automatic test_back_to_back();
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_a.p_valid = 1'b1;
            if_a.p_in    = 16'h0100;
            step();
        end
        if_a.p_valid = 1'b0;
        if_a.start   = 1'b1;
        step();
        checks++;
        if (if_a.busy !== 1'b0 || if_a.done !== 1'b0 || if_a.acc_out !== 24'h400) begin
            errors++;
            $display("FAIL b2b_done_cycle: got busy=%b done=%b acc=%0h exp 0 0 400",
                     if_a.busy, if_a.done, if_a.acc_out);
        end
        step();
        if_a.start = 1'b0;
        checks++;
        if (if_a.busy !== 1'b1 || if_a.acc_out !== 24'h0) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b acc=%0h exp 1 0",
                     if_a.busy, if_a.acc_out);
        end
        for (int i = 0; i < 4; i++) begin
            if_a.p_valid = 1'b1;
            if_a.p_in    = 16'd1;
            step();
        end
        if_a.p_valid = 1'b0;
        checks++;
        if (if_a.acc_out !== 24'd4 || if_a.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got acc=%0d done=%b exp 4 1",
                     if_a.acc_out, if_a.done);
        end
        step();
    endtask

    task automatic test_ignored_start_reset();
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            if_a.p_valid = 1'b1;
            if_a.p_in    = 16'(i);
            step();
        end
        if_a.start = 1'b1;
        if_a.p_in  = 16'd3;
        step();
        if_a.start   = 1'b0;
        if_a.p_valid = 1'b0;
        checks++;
        if (if_a.busy !== 1'b1 || if_a.acc_out !== 24'd6 || if_a.done !== 1'b0) begin
            errors++;
            $display("FAIL ign_start: got busy=%b acc=%0d done=%b exp 1 6 0",
                     if_a.busy, if_a.acc_out, if_a.done);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if_a.busy, if_a.done, if_a.ovf} !== 3'b000 || if_a.acc_out !== 24'h0) begin
            errors++;
            $display("FAIL async_rst: got busy=%b done=%b ovf=%b acc=%0h exp 0 0 0 0",
                     if_a.busy, if_a.done, if_a.ovf, if_a.acc_out);
        end
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if (if_a.busy !== 1'b0 || if_a.acc_out !== 24'h0) begin
            errors++;
            $display("FAIL rst_idle: got busy=%b acc=%0h exp 0 0",
                     if_a.busy, if_a.acc_out);
        end
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_a.p_valid = 1'b1;
            if_a.p_in    = 16'd1;
            step();
        end
        if_a.p_valid = 1'b0;
        checks++;
        if (if_a.acc_out !== 24'd4 || if_a.done !== 1'b1) begin
            errors++;
            $display("FAIL rst_rerun: got acc=%0d done=%b exp 4 1",
                     if_a.acc_out, if_a.done);
        end
        step();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        if_a.start   = 1'b0;
        if_a.clr     = 1'b0;
        if_a.p_in    = 16'h0;
        if_a.p_valid = 1'b0;
        if_b.start   = 1'b0;
        if_b.clr     = 1'b0;
        if_b.p_in    = 16'h0;
        if_b.p_valid = 1'b0;
        if_c.start   = 1'b0;
        if_c.clr     = 1'b0;
        if_c.p_in    = 16'h0;
        if_c.p_valid = 1'b0;
        test_reset();
        test_basic();
        test_bubbles();
        test_max();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_ignored_start_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
